mdio_apb_bridge: RTL and testbench

Downstream stage of the MDIO slave top: consumes its request bus (req_psel/req_penable/req_pwrite/req_paddr/req_pwdata, answered with req_pready/req_prdata) and re-issues each access as a clean APB3 transfer on the chip register bus. It adds a bounded-wait timeout, slave-error capture, and a fixed error read value, so a hung or erroring register slave never stalls the MDIO frame. All outputs are registered.

---
 rtl/mdio_apb_bridge_pkg.sv | 24 ++
 rtl/mdio_apb_bridge_if.sv | 26 ++
 rtl/mdio_apb_timeout.sv | 28 ++
 rtl/mdio_apb_bridge.sv | 107 ++++++++++
 tb/tb_mdio_apb_bridge.sv | 173 +++++++++++++++++
 5 files changed

// File: rtl/mdio_apb_bridge_pkg.sv
// rtl/mdio_apb_bridge_pkg.sv - shared MDIO register-bus types and constants
// Widths match the MDIO backend so request and APB buses line up bit for bit.
package mdio_apb_bridge_pkg;

  localparam int ADDR_W = 21;
  localparam int DATA_W = 16;
  localparam int CNT_W  = 16;
  localparam int ERR_W  = 8;

  localparam logic [DATA_W-1:0] ERR_RDATA_DEF = 16'hFFFF;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_SETUP,
    ST_ACCESS,
    ST_RESP,
    ST_DROP
  } state_t;

  function automatic logic [ERR_W-1:0] sat_inc(input logic [ERR_W-1:0] v);
    return (v == '1) ? v : v + 1'b1;
  endfunction

endpackage

// File: rtl/mdio_apb_bridge_if.sv
// rtl/mdio_apb_bridge_if.sv - APB3-style register bus used on both sides of the bridge
interface mdio_apb_bridge_if
  import mdio_apb_bridge_pkg::*;
#(
  parameter int AW = ADDR_W,
  parameter int DW = DATA_W
);
  logic          psel;
  logic          penable;
  logic          pwrite;
  logic [AW-1:0] paddr;
  logic [DW-1:0] pwdata;
  logic          pready;
  logic [DW-1:0] prdata;
  logic          pslverr;

  modport master (
    output psel, penable, pwrite, paddr, pwdata,
    input  pready, prdata, pslverr
  );

  modport slave (
    input  psel, penable, pwrite, paddr, pwdata,
    output pready, prdata, pslverr
  );
endinterface

// File: rtl/mdio_apb_timeout.sv
// rtl/mdio_apb_timeout.sv - loadable up-counter flagging the last allowed ACCESS cycle
module mdio_apb_timeout
  import mdio_apb_bridge_pkg::*;
#(
  parameter int unsigned LIMIT = 1024
) (
  input  logic clk,
  input  logic rst_n,
  input  logic load,
  input  logic en,
  output logic tc
);
  localparam logic [CNT_W-1:0] LAST = CNT_W'(LIMIT - 1);

  logic [CNT_W-1:0] cnt;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt <= '0;
    end else if (load) begin
      cnt <= '0;
    end else if (en) begin
      cnt <= cnt + 1'b1;
    end
  end

  assign tc = (cnt == LAST);
endmodule

// File: rtl/mdio_apb_bridge.sv
// rtl/mdio_apb_bridge.sv - re-issues MDIO register requests as bounded APB3 transfers
module mdio_apb_bridge
  import mdio_apb_bridge_pkg::*;
#(
  parameter int unsigned       TIMEOUT_CYC = 1024,
  parameter logic [DATA_W-1:0] ERR_RDATA   = ERR_RDATA_DEF
) (
  input  logic                 clk_200m,
  input  logic                 rstn_200m,
  mdio_apb_bridge_if.slave     req,
  mdio_apb_bridge_if.master    m,
  input  logic                 err_clr,
  output logic [ERR_W-1:0]     err_cnt,
  output logic [ADDR_W-1:0]    err_last_addr,
  output logic                 err_last_timeout
);
  state_t state, state_nxt;
  logic   cnt_load, cnt_en, cnt_tc;
  logic   done, to_evt, err_evt;
  logic   req_penable_unused;

  assign req_penable_unused = req.penable;
  assign req.pslverr        = 1'b0;

  mdio_apb_timeout #(.LIMIT(TIMEOUT_CYC)) u_timeout (
    .clk   (clk_200m),
    .rst_n (rstn_200m),
    .load  (cnt_load),
    .en    (cnt_en),
    .tc    (cnt_tc)
  );

  always_ff @(posedge clk_200m or negedge rstn_200m) begin
    if (!rstn_200m) state <= ST_IDLE;
    else            state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    cnt_load  = 1'b0;
    cnt_en    = 1'b0;
    done      = 1'b0;
    to_evt    = 1'b0;
    case (state)
      ST_IDLE:  if (req.psel) state_nxt = ST_SETUP;
      ST_SETUP: begin
        cnt_load  = 1'b1;
        state_nxt = ST_ACCESS;
      end
      ST_ACCESS: begin
        // Ready on the last counted cycle still wins over the timeout.
        if (m.pready) begin
          done      = 1'b1;
          state_nxt = ST_RESP;
        end else if (cnt_tc) begin
          done      = 1'b1;
          to_evt    = 1'b1;
          state_nxt = ST_RESP;
        end else begin
          cnt_en = 1'b1;
        end
      end
      ST_RESP:  state_nxt = ST_DROP;
      // Upstream may still hold its request during the pulse; wait for it to fall.
      ST_DROP:  if (!req.psel) state_nxt = ST_IDLE;
      default:  state_nxt = ST_IDLE;
    endcase
  end

  assign err_evt = done & (to_evt | m.pslverr);

  always_ff @(posedge clk_200m or negedge rstn_200m) begin
    if (!rstn_200m) begin
      m.psel           <= 1'b0;
      m.penable        <= 1'b0;
      m.pwrite         <= 1'b0;
      m.paddr          <= '0;
      m.pwdata         <= '0;
      req.pready       <= 1'b0;
      req.prdata       <= '0;
      err_cnt          <= '0;
      err_last_addr    <= '0;
      err_last_timeout <= 1'b0;
    end else begin
      m.psel     <= (state_nxt == ST_SETUP) || (state_nxt == ST_ACCESS);
      m.penable  <= (state_nxt == ST_ACCESS);
      req.pready <= (state_nxt == ST_RESP);
      if (state == ST_IDLE && req.psel) begin
        m.paddr  <= req.paddr;
        m.pwrite <= req.pwrite;
        m.pwdata <= req.pwdata;
      end
      if (done) begin
        req.prdata <= err_evt ? ERR_RDATA : (m.pwrite ? '0 : m.prdata);
      end
      if (err_clr) begin
        err_cnt          <= '0;
        err_last_addr    <= '0;
        err_last_timeout <= 1'b0;
      end else if (err_evt) begin
        err_cnt          <= sat_inc(err_cnt);
        err_last_addr    <= m.paddr;
        err_last_timeout <= to_evt;
      end
    end
  end
endmodule

// File: tb/tb_mdio_apb_bridge.sv
// tb/tb_mdio_apb_bridge.sv - directed bench for mdio_apb_bridge
module tb_mdio_apb_bridge;
  logic        clk_200m;
  logic        rstn_200m;
  logic        err_clr;
  logic [7:0]  err_cnt;
  logic [20:0] err_last_addr;
  logic        err_last_timeout;

  int checks   = 0;
  int failures = 0;

  int          lat, pen_cyc, setups, pulses;
  logic [15:0] rdata_seen;
  bit          wd_ok;

  mdio_apb_bridge_if req_if ();
  mdio_apb_bridge_if m_if ();

  mdio_apb_bridge #(.TIMEOUT_CYC(8)) dut (
    .clk_200m         (clk_200m),
    .rstn_200m        (rstn_200m),
    .req              (req_if),
    .m                (m_if),
    .err_clr          (err_clr),
    .err_cnt          (err_cnt),
    .err_last_addr    (err_last_addr),
    .err_last_timeout (err_last_timeout)
  );

  initial clk_200m = 1'b0;
  always #5 clk_200m = ~clk_200m;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Drives one request and plays an APB slave with the given wait/error behaviour.
  task automatic xfer(input bit wr, input logic [20:0] addr, input logic [15:0] wd,
                      input int waits, input bit never, input bit err,
                      input logic [15:0] rd, input int hold, input bit clr_at_done);
    int acc;
    bit seen;
    acc = 0; seen = 0; lat = -1; pen_cyc = 0; setups = 0; pulses = 0; wd_ok = 1;
    req_if.psel = 1; req_if.penable = 1; req_if.pwrite = wr;
    req_if.paddr = addr; req_if.pwdata = wd;
    for (int n = 1; n <= 40 && !seen; n++) begin
      @(negedge clk_200m);
      err_clr = 0;
      if (m_if.psel && !m_if.penable) setups++;
      if (m_if.penable) begin pen_cyc++; acc++; end
      if (m_if.psel && m_if.pwdata !== wd) wd_ok = 0;
      if (req_if.pready) begin seen = 1; lat = n; pulses++; rdata_seen = req_if.prdata; end
      m_if.pready  = !seen && !never && m_if.penable && (acc >= waits + 1);
      m_if.pslverr = m_if.pready && err;
      m_if.prdata  = rd;
      if (m_if.pready) err_clr = clr_at_done;
    end
    for (int h = 0; h < hold; h++) begin
      @(negedge clk_200m);
      if (req_if.pready) pulses++;
      if (m_if.psel) setups++;
    end
    req_if.psel = 0; req_if.penable = 0; m_if.pready = 0; m_if.pslverr = 0;
    repeat (2) begin
      @(negedge clk_200m);
      if (req_if.pready) pulses++;
      if (m_if.psel) setups++;
    end
  endtask

  initial begin
    rstn_200m = 0; err_clr = 0;
    req_if.psel = 0; req_if.penable = 0; req_if.pwrite = 0; req_if.paddr = '0; req_if.pwdata = '0;
    m_if.pready = 1; m_if.prdata = '0; m_if.pslverr = 0;
    repeat (2) @(negedge clk_200m);
    rstn_200m = 1;

    check("rst_m_psel", 32'(m_if.psel), 0);
    check("rst_m_penable", 32'(m_if.penable), 0);
    check("rst_req_pready", 32'(req_if.pready), 0);
    check("rst_req_prdata", 32'(req_if.prdata), 0);
    check("rst_m_paddr", 32'(m_if.paddr), 0);
    check("rst_err_cnt", 32'(err_cnt), 0);
    check("rst_err_addr", 32'(err_last_addr), 0);
    check("rst_err_to", 32'(err_last_timeout), 0);

    xfer(0, 21'h00012, 16'h0000, 0, 0, 0, 16'hA5C3, 0, 0);
    check("rd0_lat", 32'(lat), 3);
    check("rd0_data", 32'(rdata_seen), 32'hA5C3);
    check("rd0_err_cnt", 32'(err_cnt), 0);
    check("rd0_paddr_held", 32'(m_if.paddr), 32'h00012);

    xfer(1, 21'h1F000, 16'h1234, 5, 0, 0, 16'hBEEF, 0, 0);
    check("wr5_lat", 32'(lat), 8);
    check("wr5_pen_cyc", 32'(pen_cyc), 6);
    check("wr5_pwdata_held", 32'(wd_ok), 1);
    check("wr5_rdata_zero", 32'(rdata_seen), 0);
    check("wr5_pwdata_after", 32'(m_if.pwdata), 32'h1234);

    xfer(0, 21'h0ABCD, 16'h0000, 0, 1, 0, 16'h1111, 0, 0);
    check("to_pen_cyc", 32'(pen_cyc), 8);
    check("to_lat", 32'(lat), 10);
    check("to_rdata", 32'(rdata_seen), 32'hFFFF);
    check("to_err_cnt", 32'(err_cnt), 1);
    check("to_err_to", 32'(err_last_timeout), 1);
    check("to_err_addr", 32'(err_last_addr), 32'h0ABCD);

    xfer(0, 21'h00040, 16'h0000, 7, 0, 0, 16'h5A5A, 0, 0);
    check("lastcyc_lat", 32'(lat), 10);
    check("lastcyc_rdata", 32'(rdata_seen), 32'h5A5A);
    check("lastcyc_err_cnt", 32'(err_cnt), 1);

    xfer(0, 21'h00003, 16'h0000, 1, 0, 1, 16'h1234, 0, 0);
    check("slverr_rdata", 32'(rdata_seen), 32'hFFFF);
    check("slverr_err_to", 32'(err_last_timeout), 0);
    check("slverr_err_addr", 32'(err_last_addr), 3);
    check("slverr_err_cnt", 32'(err_cnt), 2);

    for (int i = 0; i < 300; i++) xfer(0, 21'(i), 16'h0000, 0, 0, 1, 16'h0000, 0, 0);
    check("sat_err_cnt", 32'(err_cnt), 255);
    check("sat_err_addr", 32'(err_last_addr), 299);

    err_clr = 1;
    @(negedge clk_200m);
    err_clr = 0;
    check("clr_err_cnt", 32'(err_cnt), 0);
    check("clr_err_addr", 32'(err_last_addr), 0);
    check("clr_err_to", 32'(err_last_timeout), 0);

    xfer(0, 21'h00055, 16'h0000, 0, 0, 1, 16'h0000, 0, 1);
    check("clrwin_err_cnt", 32'(err_cnt), 0);
    check("clrwin_err_addr", 32'(err_last_addr), 0);

    xfer(0, 21'h00100, 16'h0000, 0, 0, 0, 16'hC0DE, 4, 0);
    check("hold_lat", 32'(lat), 3);
    check("hold_pulses", 32'(pulses), 1);
    check("hold_setups", 32'(setups), 1);

    xfer(0, 21'h00101, 16'h0000, 0, 0, 0, 16'h0F0F, 0, 0);
    check("after_hold_lat", 32'(lat), 3);
    check("after_hold_rdata", 32'(rdata_seen), 32'h0F0F);

    req_if.psel = 1; req_if.penable = 1; req_if.pwrite = 0; req_if.paddr = 21'h00777;
    m_if.pready = 0;
    repeat (3) @(negedge clk_200m);
    check("midrst_pen_before", 32'(m_if.penable), 1);
    #2 rstn_200m = 0;
    #1;
    check("midrst_psel", 32'(m_if.psel), 0);
    check("midrst_penable", 32'(m_if.penable), 0);
    req_if.psel = 0; req_if.penable = 0;
    pulses = 0;
    repeat (3) begin
      @(negedge clk_200m);
      if (req_if.pready) pulses++;
    end
    check("midrst_no_pulse", 32'(pulses), 0);
    rstn_200m = 1;
    @(negedge clk_200m);

    xfer(0, 21'h00777, 16'h0000, 2, 0, 0, 16'h7E57, 0, 0);
    check("postrst_lat", 32'(lat), 5);
    check("postrst_rdata", 32'(rdata_seen), 32'h7E57);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
